// File: rtl/div_measure.sv
// Measures period and high time of an asynchronous divided clock in I_CLK cycles.
// Optional duty measurement is enabled by defining DIV_MEASURE_DUTY_EN.
module div_measure #(
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned MAX_PERIOD = 1000
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             I_DIV_CLK,
  output logic [CNT_W-1:0] O_PERIOD,
  output logic [CNT_W-1:0] O_HIGH,
  output logic             O_VALID,
  output logic             O_LOCK,
  output logic             O_TIMEOUT
);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             dly_q, dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             lock_q, lock_d;
  logic             timeout_q, timeout_d;
  logic             have_q, have_d;
  logic             rise_c;
  logic             limit_c;

  assign rise_c  = sync2_q & ~dly_q;
  assign limit_c = (cnt_q == CNT_W'(MAX_PERIOD));

  // Synchroniser, edge-detect delay, and measurement FSM next state
  always_comb begin
    sync1_d   = I_DIV_CLK;
    sync2_d   = sync1_q;
    dly_d     = sync2_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    lock_d    = lock_q;
    timeout_d = timeout_q;
    have_d    = have_q;
    case (state_q)
      IDLE: begin
        have_d = 1'b0;
        if (rise_c) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
        end
      end
      MEASURE: begin
        if (rise_c) begin
          period_d  = cnt_q;
          valid_d   = 1'b1;
          cnt_d     = CNT_W'(1);
          timeout_d = 1'b0;
          lock_d    = have_q && (cnt_q == period_q);
          have_d    = 1'b1;
        end else if (limit_c) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          lock_d    = 1'b0;
          have_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (!rst) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      dly_q     <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      lock_q    <= 1'b0;
      timeout_q <= 1'b0;
      have_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      dly_q     <= dly_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      lock_q    <= lock_d;
      timeout_q <= timeout_d;
      have_q    <= have_d;
    end
  end

`ifdef DIV_MEASURE_DUTY_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;

  // High-time counter follows the same restart points as the period counter
  always_comb begin
    hcnt_d = hcnt_q;
    high_d = high_q;
    if (state_q == IDLE) begin
      if (rise_c) hcnt_d = CNT_W'(1);
    end else if (rise_c) begin
      high_d = hcnt_q;
      hcnt_d = CNT_W'(1);
    end else if (!limit_c) begin
      hcnt_d = hcnt_q + CNT_W'(sync2_q);
    end
  end

  always_ff @(posedge I_CLK) begin
    if (!rst) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
    end
  end

  assign O_HIGH = high_q;
`else
  assign O_HIGH = '0;
`endif

  assign O_PERIOD  = period_q;
  assign O_VALID   = valid_q;
  assign O_LOCK    = lock_q;
  assign O_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_div_measure.sv
// Self-checking bench for div_measure: directed phases plus random waveforms
// checked against a cycle-count reference model of the divided clock.
module tb_div_measure;
  localparam int unsigned CNT_W      = 10;
  localparam int unsigned MAX_PERIOD = 1000;

  logic             I_CLK = 1'b0;
  logic             rst = 1'b0;
  logic             I_DIV_CLK = 1'b0;
  logic [CNT_W-1:0] O_PERIOD, O_HIGH;
  logic             O_VALID, O_LOCK, O_TIMEOUT;

  int checks = 0;
  int errors = 0;

  div_measure #(.CNT_W(CNT_W), .MAX_PERIOD(MAX_PERIOD)) dut (
    .I_CLK(I_CLK), .rst(rst), .I_DIV_CLK(I_DIV_CLK),
    .O_PERIOD(O_PERIOD), .O_HIGH(O_HIGH), .O_VALID(O_VALID),
    .O_LOCK(O_LOCK), .O_TIMEOUT(O_TIMEOUT)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic             lock;
    logic             timeout;
  } meas_t;

  meas_t obs_q[$];
  meas_t exp_q[$];

  // Reference model state: cycles since the last driven rising edge
  bit have_edge = 0;
  bit have_meas = 0;
  bit prev_v = 0;
  int since = 0;
  int hi_since = 0;
  int last_period = 0;
  bit valid_prev = 0;

  function automatic int exp_high(input int h);
`ifdef DIV_MEASURE_DUTY_EN
    return h;
`else
    return 0;
`endif
  endfunction

  always @(negedge I_CLK) begin
    if (rst === 1'b1) begin
      checks++;
      assert (!(O_VALID === 1'b1 && valid_prev)) else begin
        errors++;
        $error("FAIL valid_pulse: O_VALID high two cycles in a row, observed=1 required=0");
      end
    end
    if (O_VALID === 1'b1) obs_q.push_back('{O_PERIOD, O_HIGH, O_LOCK, O_TIMEOUT});
    valid_prev = (O_VALID === 1'b1);
  end

  task automatic tick(input bit v);
    meas_t e;
    @(posedge I_CLK);
    #1;
    if (v && !prev_v) begin
      if (have_edge && since <= int'(MAX_PERIOD)) begin
        e.period  = CNT_W'(since);
        e.high    = CNT_W'(exp_high(hi_since));
        e.lock    = have_meas && (since == last_period);
        e.timeout = 1'b0;
        exp_q.push_back(e);
        have_meas   = 1;
        last_period = since;
      end else if (have_edge) begin
        have_meas = 0;
      end
      have_edge = 1;
      since     = 1;
      hi_since  = 1;
    end else begin
      since++;
      if (v) hi_since++;
    end
    I_DIV_CLK = v;
    prev_v    = v;
  endtask

  task automatic hi(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  task automatic lo(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic wave(input int h, input int l);
    hi(h);
    lo(l);
  endtask

  task automatic drain(input string tag);
    meas_t o, e;
    @(negedge I_CLK);
    checks++;
    assert (obs_q.size() == exp_q.size()) else begin
      errors++;
      $error("FAIL %s count: observed=%0d required=%0d", tag, obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      assert (o.period === e.period && o.high === e.high &&
              o.lock === e.lock && o.timeout === e.timeout) else begin
        errors++;
        $error("FAIL %s meas: observed p=%0d h=%0d l=%0b t=%0b required p=%0d h=%0d l=%0b t=%0b",
               tag, o.period, o.high, o.lock, o.timeout, e.period, e.high, e.lock, e.timeout);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed=%0b required=%0b", tag, obs, req);
    end
  endtask

  task automatic check_val(input string tag, input logic [CNT_W-1:0] obs, input int req);
    checks++;
    assert (obs === CNT_W'(req)) else begin
      errors++;
      $error("FAIL %s: observed=%0d required=%0d", tag, obs, req);
    end
  endtask

  task automatic check_zero(input string tag);
    logic [2*CNT_W+2:0] all_o;
    all_o = {O_PERIOD, O_HIGH, O_VALID, O_LOCK, O_TIMEOUT};
    checks++;
    assert (all_o === (2*CNT_W+3)'(0)) else begin
      errors++;
      $error("FAIL %s: observed outputs=%h required=0", tag, all_o);
    end
  endtask

  task automatic do_reset();
    @(posedge I_CLK);
    #1 rst = 1'b0;
    @(posedge I_CLK);
    #1;
    check_zero("mid_reset");
    rst       = 1'b1;
    have_edge = 0;
    have_meas = 0;
  endtask

  initial begin
    int h, l, reps;
    repeat (3) @(posedge I_CLK);
    #1;
    check_zero("reset");
    rst = 1'b1;

    // Divide-by-20, then switch to period 8
    repeat (3) wave(10, 10);
    drain("div20");
    check_val("div20_period", O_PERIOD, 20);
    check_bit("div20_lock", O_LOCK, 1'b1);
    repeat (3) wave(4, 4);
    drain("div8");
    check_val("div8_period", O_PERIOD, 8);
    check_bit("div8_lock", O_LOCK, 1'b1);

    // Timeout after lock, then recovery
    repeat (3) wave(10, 10);
    drain("relock20");
    lo(975);
    check_bit("pre_timeout", O_TIMEOUT, 1'b0);
    lo(20);
    check_bit("timeout_flag", O_TIMEOUT, 1'b1);
    check_bit("timeout_lock", O_LOCK, 1'b0);
    check_val("timeout_period_hold", O_PERIOD, 20);
    hi(10);
    check_bit("timeout_after_first_edge", O_TIMEOUT, 1'b1);
    lo(10);
    repeat (2) wave(10, 10);
    drain("recover");
    check_bit("timeout_cleared", O_TIMEOUT, 1'b0);

    // Period exactly MAX_PERIOD never times out
    repeat (3) wave(500, 500);
    drain("max_period");
    check_bit("max_no_timeout", O_TIMEOUT, 1'b0);
    check_bit("max_lock", O_LOCK, 1'b1);

    // Reset mid-period while locked
    repeat (3) wave(10, 10);
    hi(10);
    lo(5);
    drain("pre_reset");
    do_reset();
    lo(5);
    repeat (2) wave(10, 10);
    lo(4);
    drain("post_reset");
    check_val("post_reset_period", O_PERIOD, 20);

    // Random waveforms with repeated periods to exercise lock
    for (int i = 0; i < 25; i++) begin
      h    = int'($urandom_range(1, 15));
      l    = int'($urandom_range(1, 15));
      reps = int'($urandom_range(1, 3));
      for (int r = 0; r < reps; r++) wave(h, l);
    end
    lo(4);
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_measure.md
DIV_MEASURE -- requirements
Module: div_measure

Interface
REQ-001 SHALL have parameter CNT_W, default 10: width of period/high-time counters and outputs.
REQ-002 SHALL have parameter MAX_PERIOD, default 1000: timeout limit in I_CLK cycles; must be < 2^CNT_W.
REQ-003 SHALL have port I_CLK  input  1  system clock, rising edge active.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port I_DIV_CLK  input  1  divided clock under measurement; may be asynchronous to I_CLK.
REQ-006 SHALL have port O_PERIOD  output  CNT_W  last measured period, in I_CLK cycles, rising edge to rising edge.
REQ-007 SHALL have port O_HIGH  output  CNT_W  last measured high time, in I_CLK cycles.
REQ-008 SHALL have port O_VALID  output  1  one-cycle pulse when O_PERIOD/O_HIGH update.
REQ-009 SHALL have port O_LOCK  output  1  high while the last two measured periods are equal.
REQ-010 SHALL have port O_TIMEOUT  output  1  sticky flag: no I_DIV_CLK rising edge within MAX_PERIOD cycles.

Function
REQ-011 SHALL synchronise I_DIV_CLK through two I_CLK flops, then register once more for edge detection; rising edge = sync high and delayed low.
REQ-012 SHALL use a fixed 3-cycle latency from I_DIV_CLK transition to edge detect; this latency SHALL NOT affect measured values.
REQ-013 SHALL implement states IDLE and MEASURE; reset enters IDLE.
REQ-014 IDLE: on detected rising edge -> MEASURE, cnt <= 1, hcnt <= 1; no O_VALID.
REQ-015 MEASURE, no edge: cnt <= cnt+1; hcnt <= hcnt+1 when sync level high.
REQ-016 MEASURE, edge: O_PERIOD <= cnt, O_HIGH <= hcnt, O_VALID <= 1 for one cycle, cnt <= 1, hcnt <= 1, O_TIMEOUT <= 0.
REQ-017 With rising edges detected N cycles apart, O_PERIOD SHALL equal N exactly.
REQ-018 On each measurement, O_LOCK <= 1 if the new period equals the previous O_PERIOD and a previous measurement exists since leaving IDLE; otherwise O_LOCK <= 0.
REQ-019 MEASURE, cnt == MAX_PERIOD and no edge: -> IDLE, O_TIMEOUT <= 1, O_LOCK <= 0; O_PERIOD/O_HIGH hold.
REQ-020 Edge and cnt == MAX_PERIOD in the same cycle: edge wins; a valid measurement of MAX_PERIOD is produced.
REQ-021 The first measurement after IDLE SHALL NOT assert O_LOCK.
REQ-022 O_VALID SHALL never be high for two consecutive cycles.
REQ-023 cnt SHALL never wrap; the timeout guarantees cnt <= MAX_PERIOD.

Reset
REQ-024 When rst is low at a rising I_CLK edge: state IDLE; all outputs, cnt, hcnt and sync flops SHALL be 0.
REQ-025 Reset mid-measurement SHALL discard the partial count; no O_VALID SHALL be produced for it.
REQ-026 After rst returns high, the first edge SHALL only start a measurement (REQ-014).

Configuration
REQ-027 Macro DIV_MEASURE_DUTY_EN defined: hcnt and O_HIGH SHALL be implemented per REQ-014 to REQ-016.
REQ-028 Macro DIV_MEASURE_DUTY_EN undefined: hcnt SHALL be absent; O_HIGH SHALL be tied to 0; all other behaviour SHALL be unchanged.

Verification
REQ-029 Drive I_DIV_CLK from a synchronous divide-by-20 (toggle every 10 cycles) -> 1st O_VALID gives O_PERIOD=20, O_HIGH=10, O_LOCK=0; 2nd gives O_LOCK=1.
REQ-030 Switch the source from period 20 to period 8 (high 4) -> the first new measurement gives O_PERIOD=8, O_LOCK=0; the next gives O_LOCK=1.
REQ-031 MAX_PERIOD=1000, hold I_DIV_CLK low after lock -> 1000 cycles after the last edge: O_TIMEOUT=1, O_LOCK=0, O_PERIOD holds 20; a new square wave clears O_TIMEOUT on its 2nd edge.
REQ-032 Period exactly 1000 -> no timeout; O_PERIOD=1000 each measurement; O_LOCK=1 from the 2nd measurement.
REQ-033 Assert rst low for 1 cycle mid-period while locked at 20 -> all outputs 0 the next cycle; the first post-reset edge gives no O_VALID; the second gives O_PERIOD=20.
REQ-034 Build without DIV_MEASURE_DUTY_EN and rerun REQ-029 -> O_HIGH=0; O_PERIOD and O_LOCK identical to REQ-029.
